// File: rtl/pipe_en_chain.sv
// Elastic DEPTH-stage register chain with valid/ready handshake, global enable,
// synchronous flush and occupancy count. Empty stages always accept (bubble collapse).
module pipe_en_chain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CNTW  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNTW-1:0]  count
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH:0]   r;
    logic [DEPTH-1:0] v_up;
    logic [WIDTH-1:0] d_up [DEPTH];
    logic             in_xfer;
    logic             out_xfer;

    // Ready ripples from the output back to stage 0; a running variable keeps
    // the chain free of combinational self-reference on r.
    always_comb begin
        logic rdy;
        rdy      = out_ready & en;
        r[DEPTH] = rdy;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy  = en & (~v[i] | rdy);
            r[i] = rdy;
        end
    end

    always_comb begin
        v_up[0] = in_valid;
        d_up[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            v_up[i] = v[i-1];
            d_up[i] = d[i-1];
        end
    end

    assign in_ready  = r[0] & ~flush & reset_n;
    assign out_valid = v[DEPTH-1] & en & ~flush;
    assign out_data  = d[DEPTH-1];
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v     <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
        end else if (flush) begin
            v     <= '0;
            count <= '0;
        end else if (en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r[i]) begin
                    v[i] <= v_up[i];
                    if (v_up[i]) begin
                        d[i] <= d_up[i];
                    end
                end
            end
            case ({in_xfer, out_xfer})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_en_chain.sv
// Directed bench for pipe_en_chain (WIDTH=8, DEPTH=3): reset, streaming,
// backpressure, bubble collapse, enable freeze and flush priority.
module tb_pipe_en_chain;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_en_chain #(.WIDTH(8), .DEPTH(3), .CNTW(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Occupancy must track the number of valid stages on every cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("count_popcount", 32'(count), 32'($countones(dut.v)));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        en        = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        reset_n = 1'b1;
        #1;

        // Reset mid-stream
        in_valid = 1'b1; in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        in_valid = 1'b0;
        #1;
        chk("t1_pre_valid", 32'(out_valid), 1);
        chk("t1_pre_data", 32'(out_data), 32'h11);
        chk("t1_pre_count", 32'(count), 3);
        #1 reset_n = 1'b0;
        #1;
        chk("t1_rst_valid", 32'(out_valid), 0);
        chk("t1_rst_count", 32'(count), 0);
        chk("t1_rst_data", 32'(out_data), 0);
        chk("t1_rst_in_ready", 32'(in_ready), 0);
        tick();
        reset_n = 1'b1;

        // Streaming 0x01..0x08, out_ready held high
        for (int c = 0; c < 12; c++) begin
            int exp_cnt;
            in_valid = (c < 8);
            in_data  = 8'(c + 1);
            #1;
            exp_cnt = ((c < 8) ? c : 8) - ((c < 3) ? 0 : ((c - 3 < 8) ? c - 3 : 8));
            chk("t2_in_ready", 32'(in_ready), 1);
            chk("t2_out_valid", 32'(out_valid), 32'((c >= 3) && (c < 11)));
            if (c >= 3 && c < 11) begin
                chk("t2_out_data", 32'(out_data), 32'(c - 2));
            end
            chk("t2_count", 32'(count), 32'(exp_cnt));
            tick();
        end
        in_valid = 1'b0;

        // Backpressure to full, then one simultaneous in/out transfer
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA1; tick();
        in_data = 8'hA2; tick();
        in_data = 8'hA3; tick();
        in_valid = 1'b0;
        #1;
        chk("t3_full_count", 32'(count), 3);
        chk("t3_full_in_ready", 32'(in_ready), 0);
        chk("t3_full_data", 32'(out_data), 32'hA1);
        chk("t3_full_valid", 32'(out_valid), 1);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA4;
        #1;
        chk("t3_full_drain_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("t3_after_count", 32'(count), 3);
        chk("t3_after_data", 32'(out_data), 32'hA2);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("t3_drained", 32'(count), 0);

        // Bubble collapse with downstream stalled
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h55; tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t4_valid", 32'(out_valid), 1);
        chk("t4_data", 32'(out_data), 32'h55);
        chk("t4_count1", 32'(count), 1);
        in_valid = 1'b1; in_data = 8'h66;
        #1;
        chk("t4_accept", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t4_count2", 32'(count), 2);
        chk("t4_in_ready", 32'(in_ready), 1);
        chk("t4_hold_data", 32'(out_data), 32'h55);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("t4_drained", 32'(count), 0);

        // Enable freeze with B1 at the output and B2 behind it
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hB1; tick();
        in_data = 8'hB2; tick();
        in_valid = 1'b0;
        tick();
        en = 1'b0; in_valid = 1'b1; in_data = 8'hB3; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t5_in_ready", 32'(in_ready), 0);
            chk("t5_out_valid", 32'(out_valid), 0);
            chk("t5_count", 32'(count), 2);
            tick();
        end
        in_valid = 1'b0; en = 1'b1;
        #1;
        chk("t5_resume_valid", 32'(out_valid), 1);
        chk("t5_resume_data", 32'(out_data), 32'hB1);
        tick();
        chk("t5_next_data", 32'(out_data), 32'hB2);
        chk("t5_next_count", 32'(count), 1);
        tick();
        chk("t5_drained", 32'(count), 0);

        // Flush overrides a disabled, full chain
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hC1; tick();
        in_data = 8'hC2; tick();
        in_data = 8'hC3; tick();
        in_valid = 1'b0;
        #1;
        chk("t6_full", 32'(count), 3);
        flush = 1'b1; en = 1'b0; in_valid = 1'b1; in_data = 8'hC4; out_ready = 1'b1;
        #1;
        chk("t6_flush_in_ready", 32'(in_ready), 0);
        chk("t6_flush_out_valid", 32'(out_valid), 0);
        tick();
        flush = 1'b0; en = 1'b1; in_valid = 1'b0;
        #1;
        chk("t6_count", 32'(count), 0);
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_data_kept", 32'(out_data), 32'hC1);
        tick();
        chk("t6_no_accept", 32'(count), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_en_chain.md
Name: pipe_en_chain

Overview:
- Parametrised successor to the single 8-bit enable flop: a DEPTH-stage, WIDTH-bit elastic pipeline register with valid/ready handshake, global enable, flush, and occupancy count.
- Sits between datapath units (e.g. ALU result to memory/writeback) wherever a multi-cycle, back-pressurable register stage is needed in place of plain enable flops.
- Collapses bubbles: an empty stage always accepts, even when downstream is stalled.

Parameters:
- WIDTH, 8, data bits per stage.
- DEPTH, 3, number of register stages (legal range 1..16).
- CNTW, 2, width of occupancy count; must satisfy 2^CNTW > DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; 0 freezes the whole chain.
- flush  in  1  synchronous clear of all valid bits.
- in_valid  in  1  upstream item present.
- in_ready  out  1  chain accepts in_data this cycle.
- in_data  in  WIDTH  upstream data.
- out_valid  out  1  item present at last stage.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  WIDTH  data of stage DEPTH-1.
- count  out  CNTW  number of valid stages (0..DEPTH).

Behaviour:
- Per stage i (0..DEPTH-1): registers v[i] (1 bit) and d[i] (WIDTH bits). Stage -1 is the input (in_valid/in_data).
- Ready chain (combinational):
  - r[DEPTH] = out_ready & en.
  - r[i] = en & (~v[i] | r[i+1]).
  - in_ready = r[0] & ~flush.
- out_valid = v[DEPTH-1] & en & ~flush.
- out_data = d[DEPTH-1], unconditionally; not masked by valid.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Clock edge, priority order:
  1. reset_n low (asynchronous, immediate): all v = 0, all d = 0, count = 0. Holds while low. Deassertion takes effect at the next edge; no handshake is lost because in_ready = 0 during reset.
  2. flush = 1: all v <= 0, count <= 0, d unchanged. Overrides en. No input is accepted and no output is presented in a flush cycle.
  3. en = 0: all registers hold; in_ready = 0 and out_valid = 0.
  4. Otherwise, for each stage with r[i] = 1: v[i] <= v[i-1]; if v[i-1] = 1 then d[i] <= d[i-1], else d holds.
- count:
  - Registered; +1 on input transfer only, -1 on output transfer only, unchanged when both or neither occur.
  - Always equals popcount(v); the bench checks this invariant every cycle.
- Latency and throughput:
  - With out_ready held at 1 and en = 1, an item accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1, i.e. DEPTH cycles from presentation to output.
  - Throughput is 1 item/cycle.
- Full: count = DEPTH and out_ready = 0 gives in_ready = 0. Full with out_ready = 1 gives in_ready = 1; simultaneous in and out transfer, count unchanged.
- Empty: count = 0 gives out_valid = 0. An item entering an empty chain with downstream stalled advances to stage DEPTH-1 before stopping (bubble collapse).
- Order is strictly preserved: no drop, no duplication.
- in_ready depends combinationally on out_ready through DEPTH gates; this is accepted for DEPTH <= 16.

Test Plan:
1. Reset mid-stream (WIDTH=8, DEPTH=3): stream 0x11, 0x22, 0x33 with out_ready=1, then pull reset_n low mid-cycle -> out_valid=0, count=0, out_data=0x00 immediately, before the next edge.
2. Streaming: in_valid=1 with 0x01..0x08 on consecutive cycles, out_ready=1 -> 0x01 is observed on the output 3 cycles after acceptance, then one item per cycle in order, count steady at 3.
3. Backpressure/full: out_ready=0, push 0xA1, 0xA2, 0xA3 -> count=3, in_ready=0, out_data=0xA1. Then out_ready=1 for one cycle while offering 0xA4 -> 0xA1 consumed, 0xA4 accepted, count stays 3.
4. Bubble collapse: load 0x55 only, out_ready=0 -> 0x55 reaches stage 2 within 3 cycles. Then push 0x66 -> accepted; count=2, in_ready stays 1.
5. Enable freeze: chain holding 0xB1, 0xB2 with en=0 for 4 cycles while in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0, count=2 unchanged. Raise en -> 0xB1 delivered next.
6. Flush priority: chain full (0xC1..0xC3), assert flush together with en=0, in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0, no output transfer, 0xC4 not accepted.
